// File: rtl/jstk_poll_scheduler.sv
// Round-robin poller for two SPI joysticks sharing one 5-byte transactor; SS setup, timeout and inter-transfer gap timing.
// Latency: SS_SETUP cycles from round start to spi_start, valid_<n> one cycle after spi_done.
// Backpressure: none; one extra poll_tick is queued while busy, any further tick sets sticky overrun.
module jstk_poll_scheduler #(
    parameter int SS_SETUP = 750,
    parameter int GAP      = 500,
    parameter int TIMEOUT  = 100000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        poll_tick,
    input  logic        enable,
    input  logic        spi_done,
    input  logic [39:0] spi_dout,
    output logic        spi_start,
    output logic        spi_sel,
    output logic        ss_1,
    output logic        ss_2,
    output logic [39:0] jstk_data_1,
    output logic [39:0] jstk_data_2,
    output logic        valid_1,
    output logic        valid_2,
    output logic [1:0]  timeout_err,
    output logic        overrun,
    output logic        busy
);

    localparam int MAX_CNT  = (TIMEOUT > SS_SETUP) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                                   : ((SS_SETUP > GAP) ? SS_SETUP : GAP);
    localparam int CNT_W    = ($clog2(MAX_CNT + 1) > 17) ? $clog2(MAX_CNT + 1) : 17;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       err_q, err_d;
    logic [39:0]      data1_q, data1_d;
    logic [39:0]      data2_q, data2_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             ss_active;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 2'b00;
            data1_q   <= '0;
            data2_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        err_d     = err_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        v1_d      = 1'b0;
        v2_d      = 1'b0;
        spi_start = 1'b0;

        // Ticks arriving mid-round queue one deep; a second queued tick is lost.
        if (poll_tick && (state_q != IDLE)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if ((poll_tick || pending_q) && enable) begin
                    pending_d = 1'b0;
                    sel_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    spi_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                // A done landing on the final timeout count still counts as success.
                if (spi_done) begin
                    if (sel_q) begin
                        data2_d = spi_dout;
                        v2_d    = 1'b1;
                    end else begin
                        data1_d = spi_dout;
                        v1_d    = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_d[sel_q] = 1'b1;
                    cnt_d        = '0;
                    state_d      = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (!sel_q && enable) begin
                        sel_d   = 1'b1;
                        state_d = SETUP;
                    end else begin
                        sel_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ss_active   = (state_q == SETUP) || (state_q == XFER);
    assign ss_1        = !(ss_active && !sel_q);
    assign ss_2        = !(ss_active && sel_q);
    assign spi_sel     = sel_q;
    assign busy        = (state_q != IDLE);
    assign jstk_data_1 = data1_q;
    assign jstk_data_2 = data2_q;
    assign valid_1     = v1_q;
    assign valid_2     = v2_q;
    assign timeout_err = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Directed bench for jstk_poll_scheduler with a behavioural SPI transactor and an SS/valid monitor.
module tb_jstk_poll_scheduler;

    localparam int SS_SETUP = 750;
    localparam int GAP      = 500;
    localparam int TIMEOUT  = 2000;

    logic        clk;
    logic        clr_n;
    logic        poll_tick;
    logic        enable;
    logic        spi_done;
    logic [39:0] spi_dout;
    logic        spi_start;
    logic        spi_sel;
    logic        ss_1;
    logic        ss_2;
    logic [39:0] jstk_data_1;
    logic [39:0] jstk_data_2;
    logic        valid_1;
    logic        valid_2;
    logic [1:0]  timeout_err;
    logic        overrun;
    logic        busy;

    jstk_poll_scheduler #(.SS_SETUP(SS_SETUP), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr_n(clr_n), .poll_tick(poll_tick), .enable(enable),
        .spi_done(spi_done), .spi_dout(spi_dout), .spi_start(spi_start), .spi_sel(spi_sel),
        .ss_1(ss_1), .ss_2(ss_2), .jstk_data_1(jstk_data_1), .jstk_data_2(jstk_data_2),
        .valid_1(valid_1), .valid_2(valid_2), .timeout_err(timeout_err),
        .overrun(overrun), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Transactor controls, written only by the main sequence.
    logic [39:0] tx_dat [2];
    int          tx_dly [2];
    bit          tx_silent [2];
    int          spur_cnt = 0;
    logic [39:0] spur_dat = '0;

    // Responds tx_dly cycles after spi_start; silent channels never answer.
    initial begin : xactor
        int cd = 0;
        int ch = 0;
        int spur_seen = 0;
        spi_done = 1'b0;
        spi_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                spi_done  = 1'b1;
                spi_dout  = spur_dat;
            end else if (spi_start) begin
                ch = int'(spi_sel);
                cd = tx_silent[ch] ? 0 : tx_dly[ch];
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    spi_done = 1'b1;
                    spi_dout = tx_dat[ch];
                end
            end
        end
    end

    int cyc = 0, run1 = 0, run2 = 0, bh = 0;
    int setup_len1 = 0, setup_len2 = 0, low_len2 = 0, gap12 = 0;
    int n_start = 0, n_v1 = 0, n_v2 = 0, n_fall1 = 0, n_fall2 = 0, last_fall = 0;
    int viol = 0, t_done = 0, v1_lat = 0;
    logic prev1 = 1'b1, prev2 = 1'b1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if ((!ss_1 && !ss_2) || (!ss_1 && spi_sel) || (!ss_2 && !spi_sel) ||
                ((!ss_1 || !ss_2) && !busy))
                viol++;
            if (prev1 && !ss_1) begin n_fall1++; last_fall = 1; end
            if (prev2 && !ss_2) begin n_fall2++; last_fall = 2; gap12 = bh; end
            if (ss_1 && ss_2) bh++; else bh = 0;
            if (!ss_1) run1++; else run1 = 0;
            if (!ss_2) run2++;
            else begin
                if (!prev2) low_len2 = run2;
                run2 = 0;
            end
            if (spi_start) begin
                n_start++;
                if (!ss_1) setup_len1 = run1;
                if (!ss_2) setup_len2 = run2;
            end
            if (spi_done) t_done = cyc;
            if (valid_1) begin n_v1++; v1_lat = cyc - t_done; end
            if (valid_2) n_v2++;
            prev1 = ss_1;
            prev2 = ss_2;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk) poll_tick = 1'b1;
        @(negedge clk) poll_tick = 1'b0;
    endtask

    // Idle means busy low for four consecutive cycles, so the one-cycle IDLE between queued rounds is skipped.
    task automatic wait_quiet(input string tag, input int bound);
        int q = 0;
        for (int i = 0; i < bound && q < 4; i++) begin
            @(negedge clk);
            if (busy) q = 0; else q++;
        end
        check(tag, 64'(q >= 4), 64'd1);
    endtask

    task automatic wait_start(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (spi_start) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    int b_v1, b_v2, b_start, b_f1, b_f2;

    task automatic snap();
        b_v1 = n_v1; b_v2 = n_v2; b_start = n_start; b_f1 = n_fall1; b_f2 = n_fall2;
    endtask

    initial begin : main
        clr_n     = 1'b0;
        poll_tick = 1'b0;
        enable    = 1'b1;
        tx_dat[0] = 40'h12_3456_789A;
        tx_dat[1] = 40'hA5_A5A5_A5A5;
        tx_dly[0] = 80;
        tx_dly[1] = 80;
        tx_silent[0] = 1'b0;
        tx_silent[1] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ss",      {62'd0, ss_1, ss_2}, 64'h3);
        check("rst_start",   64'(spi_start), 64'd0);
        check("rst_sel",     64'(spi_sel), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_data1",   64'(jstk_data_1), 64'd0);
        check("rst_data2",   64'(jstk_data_2), 64'd0);
        check("rst_valid",   {62'd0, valid_1, valid_2}, 64'd0);
        check("rst_err",     64'(timeout_err), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk) clr_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_tick", 64'(busy), 64'd0);

        // Full round, both channels answer after 80 cycles.
        pulse_tick();
        wait_quiet("a_quiet", 10000);
        check("a_setup1",  64'(setup_len1), 64'd750);
        check("a_vlat",    64'(v1_lat), 64'd1);
        check("a_data1",   64'(jstk_data_1), 64'h12_3456_789A);
        check("a_gap",     64'(gap12), 64'd500);
        check("a_setup2",  64'(setup_len2), 64'd750);
        check("a_data2",   64'(jstk_data_2), 64'hA5_A5A5_A5A5);
        check("a_nv1",     64'(n_v1), 64'd1);
        check("a_nv2",     64'(n_v2), 64'd1);
        check("a_nstart",  64'(n_start), 64'd2);
        check("a_err",     64'(timeout_err), 64'd0);
        check("a_overrun", 64'(overrun), 64'd0);

        // Channel 1 silent: timeout after TIMEOUT cycles in XFER.
        tx_silent[1] = 1'b1;
        snap();
        pulse_tick();
        wait_quiet("b_quiet", 10000);
        check("b_err",     64'(timeout_err), 64'h2);
        check("b_data2",   64'(jstk_data_2), 64'hA5_A5A5_A5A5);
        check("b_nv2",     64'(n_v2 - b_v2), 64'd0);
        check("b_nv1",     64'(n_v1 - b_v1), 64'd1);
        check("b_ss2_low", 64'(low_len2), 64'(SS_SETUP + TIMEOUT));
        check("b_overrun", 64'(overrun), 64'd0);

        // Three ticks in one round: one extra round, overrun set.
        tx_silent[1] = 1'b0;
        tx_dat[0] = 40'h01_0203_0405;
        snap();
        pulse_tick();
        repeat (100) @(negedge clk);
        pulse_tick();
        repeat (100) @(negedge clk);
        pulse_tick();
        check("c_overrun_now", 64'(overrun), 64'd1);
        wait_quiet("c_quiet", 20000);
        check("c_nstart",  64'(n_start - b_start), 64'd4);
        check("c_nv1",     64'(n_v1 - b_v1), 64'd2);
        check("c_data1",   64'(jstk_data_1), 64'h01_0203_0405);
        check("c_overrun", 64'(overrun), 64'd1);

        // Enable drops during channel 0 XFER.
        snap();
        pulse_tick();
        wait_start("d_start", 2000);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_quiet("d_quiet", 10000);
        check("d_nv1",    64'(n_v1 - b_v1), 64'd1);
        check("d_nfall2", 64'(n_fall2 - b_f2), 64'd0);
        check("d_nstart", 64'(n_start - b_start), 64'd1);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("d_stay_idle", 64'(busy), 64'd0);

        // Spurious spi_done while IDLE.
        spur_dat = 40'hDE_ADBE_EF00;
        snap();
        spur_cnt++;
        repeat (5) @(negedge clk);
        check("e_spur_data1", 64'(jstk_data_1), 64'h01_0203_0405);
        check("e_spur_data2", 64'(jstk_data_2), 64'hA5_A5A5_A5A5);
        check("e_spur_valid", 64'((n_v1 - b_v1) + (n_v2 - b_v2)), 64'd0);
        check("e_spur_busy",  64'(busy), 64'd0);

        // Done on the final timeout count wins.
        tx_dly[0] = TIMEOUT;
        tx_dat[0] = 40'h0B_ADC0_FFEE;
        snap();
        pulse_tick();
        wait_quiet("e_coinc_quiet", 20000);
        check("e_coinc_err",   64'(timeout_err), 64'h2);
        check("e_coinc_data1", 64'(jstk_data_1), 64'h0B_ADC0_FFEE);
        check("e_coinc_nv1",   64'(n_v1 - b_v1), 64'd1);

        // One cycle later is a timeout; the late done in HOLD is ignored.
        tx_dly[0] = TIMEOUT + 1;
        tx_dat[0] = 40'h11_1111_1111;
        snap();
        pulse_tick();
        wait_quiet("e_late_quiet", 20000);
        check("e_late_err",   64'(timeout_err), 64'h3);
        check("e_late_data1", 64'(jstk_data_1), 64'h0B_ADC0_FFEE);
        check("e_late_nv1",   64'(n_v1 - b_v1), 64'd0);
        check("e_late_nv2",   64'(n_v2 - b_v2), 64'd1);

        // Reset mid-XFER on channel 0, checked before the next clock edge.
        tx_dly[0] = 80;
        tx_dat[0] = 40'h22_2222_2222;
        pulse_tick();
        wait_start("f_start", 2000);
        repeat (20) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("f_ss",      {62'd0, ss_1, ss_2}, 64'h3);
        check("f_start0",  64'(spi_start), 64'd0);
        check("f_sel",     64'(spi_sel), 64'd0);
        check("f_busy",    64'(busy), 64'd0);
        check("f_data",    {24'd0, jstk_data_1}, 64'd0);
        check("f_err",     64'(timeout_err), 64'd0);
        check("f_overrun", 64'(overrun), 64'd0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        repeat (100) @(negedge clk);
        check("f_no_latch", 64'(jstk_data_1), 64'd0);
        snap();
        pulse_tick();
        repeat (2) @(negedge clk);
        check("f_first_ch",  64'(last_fall), 64'd1);
        check("f_nfall1",    64'(n_fall1 - b_f1), 64'd1);
        check("f_sel_first", 64'(spi_sel), 64'd0);
        wait_quiet("f_quiet", 10000);
        check("f_data1", 64'(jstk_data_1), 64'h22_2222_2222);
        check("f_data2", 64'(jstk_data_2), 64'hA5_A5A5_A5A5);
        check("f_err_end", 64'(timeout_err), 64'd0);
        check("ss_rules",  64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jstk_poll_scheduler.md
JSTK_POLL_SCHEDULER -- requirements
Module: jstk_poll_scheduler

Interface
REQ-001 Parameter: SS_SETUP, default 750, clk cycles between SS low and spi_start (15 us at 50 MHz).
REQ-002 Parameter: GAP, default 500, clk cycles SS is held high after a transfer before the next channel may be selected.
REQ-003 Parameter: TIMEOUT, default 100000, clk cycles allowed from spi_start to spi_done.
REQ-004 clk  in  1  system clock, 50 MHz; all state on rising edge.
REQ-005 clr_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 poll_tick  in  1  one-cycle pulse from the clock divider requesting one polling round.
REQ-007 enable  in  1  level; 0 stops new rounds.
REQ-008 spi_done  in  1  one-cycle pulse from the shared SPI transactor; spi_dout valid this cycle.
REQ-009 spi_dout  in  40  joystick frame from the transactor.
REQ-010 spi_start  out  1  one-cycle pulse starting a 5-byte transfer.
REQ-011 spi_sel  out  1  channel being served: 0 = joystick 1, 1 = joystick 2.
REQ-012 ss_1, ss_2  out  1 each  active-low slave selects.
REQ-013 jstk_data_1, jstk_data_2  out  40 each  last good frame per channel.
REQ-014 valid_1, valid_2  out  1 each  one-cycle pulse when the matching register updates.
REQ-015 timeout_err  out  2  sticky per channel; bit0 = joystick 1.
REQ-016 overrun  out  1  sticky; a poll_tick was dropped.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, XFER, HOLD; exactly one state active at a time.
REQ-019 A round polls channel 0, then channel 1, in that fixed order.
REQ-020 IDLE: when (poll_tick or pending) and enable are true, the block clears pending, sets spi_sel=0, drives the selected SS low, clears the counter, and enters SETUP next cycle.
REQ-021 SETUP: the counter increments each cycle; when the count reaches SS_SETUP-1, spi_start pulses for one cycle and the FSM enters XFER with the counter cleared.
REQ-022 XFER: on spi_done, spi_dout is latched into jstk_data_<sel>; valid_<sel> pulses in the cycle after spi_done; the FSM enters HOLD.
REQ-023 XFER timeout: with no spi_done by count TIMEOUT-1, timeout_err[sel] is set, the data register is kept, no valid pulse is issued, and the FSM enters HOLD.
REQ-024 If spi_done and timeout occur in the same cycle, done takes priority and timeout_err is not set.
REQ-025 HOLD: both SS lines stay high for GAP cycles.
REQ-026 At HOLD exit with spi_sel=0 and enable=1, spi_sel becomes 1 and the FSM enters SETUP; otherwise it enters IDLE with spi_sel=0.
REQ-027 enable falling mid-round: the current transfer and HOLD complete, then the FSM returns to IDLE, skipping channel 1 if not yet started.
REQ-028 poll_tick while busy sets pending (one deep); poll_tick while pending is already set sets overrun.
REQ-029 spi_done outside XFER is ignored.
REQ-030 At most one SS is low at any time; an SS is low only in SETUP or XFER, and only ss_<sel+1>.
REQ-031 Counters are 17 bits minimum; no wrap-around within any state.
REQ-032 Sticky flags clear only on reset.

Reset
REQ-033 While clr_n=0, all of the following hold immediately: state=IDLE; ss_1=ss_2=1; spi_start=0; spi_sel=0; data registers=0; valid=0; timeout_err=0; overrun=0; pending=0; busy=0; counters=0.
REQ-034 Reset asserted mid-transfer aborts the transfer with no data latch; the first poll after release starts at channel 0.

Verification
REQ-035 Reset, then one poll_tick with enable=1 and a transactor model returning 0x12_3456_789A after 80 cycles -> ss_1 low for 750 cycles before spi_start; jstk_data_1=0x123456789A with valid_1 pulsed; then channel 1 is polled after a 500-cycle gap; busy=0 at the end.
REQ-036 Transactor silent on channel 1 -> timeout_err=2'b10 after 100000 cycles in XFER; jstk_data_2 unchanged; no valid_2 pulse; FSM returns to IDLE.
REQ-037 Three poll_ticks during one round -> exactly one extra round runs; overrun=1.
REQ-038 enable dropped during channel 0 XFER -> channel 0 completes, channel 1 is never selected, FSM goes to IDLE.
REQ-039 spi_done coincident with timeout count; spurious spi_done in IDLE -> done wins with no error set; the spurious pulse has no effect.
REQ-040 clr_n low mid-XFER -> ss_1=ss_2=1 and all outputs at reset values without a clock edge; the next round starts with spi_sel=0.
